// File: rtl/mcu_input_conditioner_if.sv
// Raw board inputs and conditioned core-side outputs of the MCU input conditioner.
// The board side drives raw_*; the conditioner drives prt*I, _INT, chg and int_state.
interface mcu_input_conditioner_if;
    logic [3:0] rawA;
    logic [3:0] rawB;
    logic [3:0] rawC;
    logic [3:0] rawD;
    logic       raw_int;
    logic [3:0] prtAI;
    logic [3:0] prtBI;
    logic [3:0] prtCI;
    logic [3:0] prtDI;
    logic       _INT;
    logic       chg;
    logic       int_state;  // debug view of the _INT pulse FSM: 1 while in PULSE

    modport master (
        output rawA, rawB, rawC, rawD, raw_int,
        input  prtAI, prtBI, prtCI, prtDI, _INT, chg, int_state
    );
    modport slave (
        input  rawA, rawB, rawC, rawD, raw_int,
        output prtAI, prtBI, prtCI, prtDI, _INT, chg, int_state
    );
endinterface

// File: rtl/mcu_input_conditioner.sv
// Synchronises and debounces 16 port bits plus an interrupt source for the MCU core,
// turning a debounced falling edge of the interrupt into a fixed-width low pulse on _INT.
module mcu_input_conditioner #(
    parameter int         DIV       = 1000,
    parameter int         DEB       = 4,
    parameter int         INT_PULSE = 4,
    parameter logic [3:0] PORT_RST  = 4'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    mcu_input_conditioner_if.slave  bus
);
    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [3:0]  DEB_LAST   = 4'(DEB - 1);
    localparam logic [7:0]  PULSE_LAST = 8'(INT_PULSE - 1);
    localparam logic [16:0] STABLE_RST = {1'b0, {4{PORT_RST}}};

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} int_state_t;

    // Bit 16 is the interrupt source; bits 15:0 are ports D,C,B,A from high to low.
    logic [16:0]      raw_all;
    logic [16:0]      sync1;
    logic [16:0]      sync2;
    logic [16:0]      stable;
    logic [16:0]      stable_nxt;
    logic [16:0]      flip;
    logic [16:0][3:0] cnt;
    logic [16:0][3:0] cnt_nxt;
    logic [15:0]      pre;
    logic             tick;
    logic             chg_q;
    logic             int_n;
    logic             int_fall;
    logic [7:0]       pcnt;
    int_state_t       state;

    assign raw_all = {bus.raw_int, bus.rawD, bus.rawC, bus.rawB, bus.rawA};
    assign tick    = (pre == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            pre   <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
            pre   <= tick ? 16'd0 : pre + 16'd1;
        end
    end

    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = cnt;
        flip       = '0;
        if (tick) begin
            for (int b = 0; b < 17; b++) begin
                if (sync2[b] != stable[b]) begin
                    if (cnt[b] == DEB_LAST) begin
                        stable_nxt[b] = sync2[b];
                        cnt_nxt[b]    = 4'd0;
                        flip[b]       = 1'b1;
                    end else begin
                        cnt_nxt[b] = cnt[b] + 4'd1;
                    end
                end else begin
                    cnt_nxt[b] = 4'd0;
                end
            end
        end
    end

    // A flip of bit 16 away from 1 is the debounced falling edge of the interrupt.
    assign int_fall = flip[16] & stable[16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= STABLE_RST;
            cnt    <= '0;
            chg_q  <= 1'b0;
        end else begin
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            chg_q  <= |flip[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            int_n <= 1'b1;
            pcnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_fall) begin
                        state <= PULSE;
                        int_n <= 1'b0;
                        pcnt  <= PULSE_LAST;
                    end
                end
                PULSE: begin
                    if (pcnt == 8'd0) begin
                        state <= IDLE;
                        int_n <= 1'b1;
                    end else begin
                        pcnt <= pcnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    int_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.prtAI     = stable[3:0];
    assign bus.prtBI     = stable[7:4];
    assign bus.prtCI     = stable[11:8];
    assign bus.prtDI     = stable[15:12];
    assign bus._INT      = int_n;
    assign bus.chg       = chg_q;
    assign bus.int_state = (state == PULSE);
endmodule

// File: tb/tb_mcu_input_conditioner.sv
// Bench for mcu_input_conditioner: three parameterisations checked against a tick-level
// reference model plus directed expectations for each scenario.
module tb_mcu_input_conditioner;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mcu_input_conditioner_if bus0 ();
    mcu_input_conditioner_if bus1 ();
    mcu_input_conditioner_if bus2 ();

    mcu_input_conditioner #(.DIV(4), .DEB(3), .INT_PULSE(4), .PORT_RST(4'h0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    mcu_input_conditioner #(.DIV(4), .DEB(3), .INT_PULSE(200), .PORT_RST(4'h0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    mcu_input_conditioner #(.DIV(2), .DEB(1), .INT_PULSE(4), .PORT_RST(4'h0)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Reference model, one slot per instance: edge count since release, the raw values of
    // the last two edges, stable values, consecutive-disagreement run lengths, and the
    // edge index at which the current _INT low pulse ends.
    logic [16:0] m_h1[3];
    logic [16:0] m_h2[3];
    logic [16:0] m_stab[3];
    int          m_run[3][17];
    int          m_ecnt[3];
    int          m_low[3];
    logic        m_chg[3];

    function automatic int div_of(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int deb_of(input int i);
        return (i == 2) ? 1 : 3;
    endfunction

    function automatic int pulse_of(input int i);
        return (i == 1) ? 200 : 4;
    endfunction

    function automatic logic [16:0] raw_of(input int i);
        case (i)
            0:       return {bus0.raw_int, bus0.rawD, bus0.rawC, bus0.rawB, bus0.rawA};
            1:       return {bus1.raw_int, bus1.rawD, bus1.rawC, bus1.rawB, bus1.rawA};
            default: return {bus2.raw_int, bus2.rawD, bus2.rawC, bus2.rawB, bus2.rawA};
        endcase
    endfunction

    function automatic logic [17:0] dut_obs(input int i);
        case (i)
            0:       return {bus0.prtDI, bus0.prtCI, bus0.prtBI, bus0.prtAI, bus0._INT, bus0.chg};
            1:       return {bus1.prtDI, bus1.prtCI, bus1.prtBI, bus1.prtAI, bus1._INT, bus1.chg};
            default: return {bus2.prtDI, bus2.prtCI, bus2.prtBI, bus2.prtAI, bus2._INT, bus2.chg};
        endcase
    endfunction

    function automatic logic [17:0] exp_obs(input int i);
        return {m_stab[i][15:0], (m_ecnt[i] >= m_low[i]), m_chg[i]};
    endfunction

    task automatic model_reset(input int i);
        m_h1[i]   = '0;
        m_h2[i]   = '0;
        m_stab[i] = '0;
        for (int b = 0; b < 17; b++) m_run[i][b] = 0;
        m_ecnt[i] = 0;
        m_low[i]  = 0;
        m_chg[i]  = 1'b0;
    endtask

    task automatic model_step(input int i);
        logic [16:0] smp;
        logic        fall;
        int          e;
        e         = m_ecnt[i] + 1;
        m_ecnt[i] = e;
        smp       = m_h2[i];
        m_h2[i]   = m_h1[i];
        m_h1[i]   = raw_of(i);
        m_chg[i]  = 1'b0;
        fall      = 1'b0;
        if (e % div_of(i) == 0) begin
            for (int b = 0; b < 17; b++) begin
                if (smp[b] != m_stab[i][b]) begin
                    m_run[i][b]++;
                    if (m_run[i][b] == deb_of(i)) begin
                        m_stab[i][b] = smp[b];
                        m_run[i][b]  = 0;
                        if (b < 16) m_chg[i] = 1'b1;
                        else if (!smp[b]) fall = 1'b1;
                    end
                end else begin
                    m_run[i][b] = 0;
                end
            end
        end
        if (fall && e > m_low[i]) m_low[i] = e + pulse_of(i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) model_reset(i);
        forever begin
            @(posedge clk or negedge reset);
            for (int i = 0; i < 3; i++) begin
                if (!reset) model_reset(i);
                else model_step(i);
            end
        end
    end

    task automatic drive_raw(input int i, input logic [16:0] v);
        case (i)
            0:       {bus0.raw_int, bus0.rawD, bus0.rawC, bus0.rawB, bus0.rawA} = v;
            1:       {bus1.raw_int, bus1.rawD, bus1.rawC, bus1.rawB, bus1.rawA} = v;
            default: {bus2.raw_int, bus2.rawD, bus2.rawC, bus2.rawB, bus2.rawA} = v;
        endcase
    endtask

    task automatic align(input int i);
        while (m_ecnt[i] % div_of(i) != 0) @(negedge clk);
    endtask

    task automatic test_reset();
        int chg_cnt;
        for (int i = 0; i < 3; i++) drive_raw(i, 17'h0);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (dut_obs(i) !== {16'h0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset_state u%0d got=%h exp=%h", i, dut_obs(i), {16'h0, 1'b1, 1'b0});
            end
        end
        @(negedge clk);
        reset = 1'b1;
        bus0.rawA = 4'hF;
        repeat (20) begin
            @(negedge clk);
            total++;
            if (dut_obs(0) !== exp_obs(0)) begin
                bad++;
                $display("FAIL reset_run got=%h exp=%h", dut_obs(0), exp_obs(0));
            end
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus0.prtAI, bus0._INT, bus0.chg} !== {4'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_midrun got=%h exp=%h", {bus0.prtAI, bus0._INT, bus0.chg}, {4'h0, 1'b1, 1'b0});
        end
        @(negedge clk);
        reset   = 1'b1;
        chg_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if (bus0.prtAI !== ((k >= 12) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL reset_relearn k=%0d got=%h exp=%h", k, bus0.prtAI, (k >= 12) ? 4'hF : 4'h0);
            end
            if (bus0.chg === 1'b1) chg_cnt++;
        end
        total++;
        if (chg_cnt != 1) begin
            bad++;
            $display("FAIL reset_chg_count got=%0d exp=1", chg_cnt);
        end
    endtask

    task automatic test_glitch();
        int chg_cnt;
        align(0);
        chg_cnt   = 0;
        bus0.rawB = 4'h4;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            total++;
            if (dut_obs(0) !== exp_obs(0)) begin
                bad++;
                $display("FAIL glitch_model k=%0d got=%h exp=%h", k, dut_obs(0), exp_obs(0));
            end
            if (bus0.chg === 1'b1) chg_cnt++;
            if (k == 8) bus0.rawB = 4'h0;
        end
        total++;
        if (bus0.prtBI !== 4'h0 || chg_cnt != 0) begin
            bad++;
            $display("FAIL glitch_reject got=%h/%0d exp=0/0", bus0.prtBI, chg_cnt);
        end
        align(0);
        chg_cnt   = 0;
        bus0.rawB = 4'h4;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if ({bus0.prtBI, bus0.chg} !== {((k >= 12) ? 4'h4 : 4'h0), (k == 12)}) begin
                bad++;
                $display("FAIL glitch_hold k=%0d got=%h exp=%h", k, {bus0.prtBI, bus0.chg},
                         {((k >= 12) ? 4'h4 : 4'h0), (k == 12)});
            end
            if (bus0.chg === 1'b1) chg_cnt++;
        end
        total++;
        if (chg_cnt != 1) begin
            bad++;
            $display("FAIL glitch_chg_count got=%0d exp=1", chg_cnt);
        end
    endtask

    task automatic test_int_pulse();
        align(0);
        bus0.raw_int = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            total++;
            if (dut_obs(0) !== exp_obs(0)) begin
                bad++;
                $display("FAIL int_model k=%0d got=%h exp=%h", k, dut_obs(0), exp_obs(0));
            end
            total++;
            if (bus0._INT !== ((k >= 24 && k < 28) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL int_pulse k=%0d got=%b exp=%b", k, bus0._INT, (k >= 24 && k < 28) ? 1'b0 : 1'b1);
            end
            if (k == 12) bus0.raw_int = 1'b0;
        end
    endtask

    task automatic test_multi();
        int chg_cnt;
        align(0);
        chg_cnt   = 0;
        bus0.rawA = 4'h5;
        bus0.rawC = 4'hA;
        bus0.rawD = 4'h1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            total++;
            if ({bus0.prtDI, bus0.prtCI, bus0.prtBI, bus0.prtAI} !== ((k >= 12) ? 16'h1A45 : 16'h004F)) begin
                bad++;
                $display("FAIL multi_ports k=%0d got=%h exp=%h", k,
                         {bus0.prtDI, bus0.prtCI, bus0.prtBI, bus0.prtAI}, (k >= 12) ? 16'h1A45 : 16'h004F);
            end
            if (bus0.chg === 1'b1) chg_cnt++;
        end
        total++;
        if (chg_cnt != 1) begin
            bad++;
            $display("FAIL multi_chg_count got=%0d exp=1", chg_cnt);
        end
    endtask

    task automatic test_int_overlap();
        align(1);
        bus1.raw_int = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            total++;
            if (bus1._INT !== ((k >= 24 && k < 224) ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL overlap_pulse k=%0d got=%b exp=%b", k, bus1._INT, (k >= 24 && k < 224) ? 1'b0 : 1'b1);
            end
            if (k == 12 || k == 36) bus1.raw_int = 1'b0;
            if (k == 24) bus1.raw_int = 1'b1;
        end
        align(1);
        bus1.raw_int = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            total++;
            if (dut_obs(1) !== exp_obs(1)) begin
                bad++;
                $display("FAIL overlap_model k=%0d got=%h exp=%h", k, dut_obs(1), exp_obs(1));
            end
            if (k == 12) bus1.raw_int = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus1._INT, bus1.chg, bus1.int_state} !== 3'b100) begin
            bad++;
            $display("FAIL reset_mid_pulse got=%b exp=100", {bus1._INT, bus1.chg, bus1.int_state});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            total++;
            if (bus1._INT !== 1'b1) begin
                bad++;
                $display("FAIL pulse_no_carry got=%b exp=1", bus1._INT);
            end
        end
    endtask

    task automatic test_follow();
        logic       cur;
        logic [3:0] e;
        align(2);
        cur = 1'b1;
        bus2.rawD[0] = cur;
        exp_q.push_back({3'b000, cur});
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            total++;
            if (dut_obs(2) !== exp_obs(2)) begin
                bad++;
                $display("FAIL follow_model k=%0d got=%h exp=%h", k, dut_obs(2), exp_obs(2));
            end
            if (k % 2 == 0 && k >= 4 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({bus2.prtDI, bus2.chg} !== {e, 1'b1}) begin
                    bad++;
                    $display("FAIL follow_tick k=%0d got=%h exp=%h", k, {bus2.prtDI, bus2.chg}, {e, 1'b1});
                end
            end else begin
                total++;
                if (bus2.chg !== 1'b0) begin
                    bad++;
                    $display("FAIL follow_quiet k=%0d got=%b exp=0", k, bus2.chg);
                end
            end
            if (k % 2 == 0 && k <= 18) begin
                cur = ~cur;
                bus2.rawD[0] = cur;
                exp_q.push_back({3'b000, cur});
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] v;
        int          hold;
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    v = 17'($urandom);
                    drive_raw(i, v);
                end
            end
            hold = $urandom_range(1, 14);
            repeat (hold) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (dut_obs(i) !== exp_obs(i)) begin
                        bad++;
                        $display("FAIL random_u%0d it=%0d got=%h exp=%h", i, it, dut_obs(i), exp_obs(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_int_pulse();
        test_multi();
        test_int_overlap();
        test_follow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
